// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types, error codes and default parameters for the
// UART byte-stream deframer (uart_frame_rx) and its payload FIFO.
package uart_frame_pkg;

   // Deframer states; ST_CHECK is only entered when the CHK byte is enabled.
   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } frame_state_t;

   // Reason codes reported on err_code for a dropped frame.
   localparam logic [1:0] ERR_LEN      = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_CHECKSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // Default frame start byte and sizing.
   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
   localparam int          MAX_LEN_DEF = 16;
   localparam int          DEPTH_DEF   = 32;
   localparam logic [15:0] TIMEOUT_DEF = 16'd50000;

endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: DEPTH-entry FIFO of {last, data} words with a speculative write
// pointer. Writes advance wr_ptr; commit publishes everything written so far
// to the reader (commit_ptr); rollback rewinds wr_ptr to the last commit.
// The reader only ever sees entries below commit_ptr.
module frame_fifo #(
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     nRst,
   input  logic                     wr_en_i,
   input  logic [7:0]               wr_data_i,
   input  logic                     wr_last_i,
   input  logic                     commit_i,
   input  logic                     rollback_i,
   input  logic                     rd_en_i,
   output logic                     rd_valid_o,
   output logic [7:0]               rd_data_o,
   output logic                     rd_last_o,
   output logic [$clog2(DEPTH):0]   free_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   logic [8:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          full;
   logic          wr_go;
   logic          rd_go;
   logic [8:0]    rd_word;

   // Full when pointers differ only in the wrap bit.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_go = wr_en_i & ~full;
   assign rd_valid_o = (rd_ptr_q != commit_ptr_q);
   assign rd_go = rd_en_i & rd_valid_o;
   assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_data_o = rd_valid_o ? rd_word[7:0] : 8'h00;
   assign rd_last_o = rd_valid_o & rd_word[8];
   // Occupancy counts uncommitted entries too, they hold real storage.
   assign free_o = DEPTH_P - (wr_ptr_q - rd_ptr_q);

   // Pointer next-state: a commit in the same cycle as a write includes it.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (rollback_i) begin
         wr_ptr_d = commit_ptr_q;
      end else if (wr_go) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (commit_i) begin
         commit_ptr_d = wr_ptr_d;
      end
      if (rd_go) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers; reset empties the FIFO including committed data.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Storage array; contents are only meaningful below the pointers.
   always_ff @(posedge clk) begin
      if (wr_go) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {wr_last_i, wr_data_i};
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: deframes the UART byte stream. Hunts for SYNC, reads LEN,
// buffers LEN payload bytes speculatively and publishes them only once the
// frame is complete (and, with the CHK byte enabled, verified).
// Build option: define FRAME_CHECKSUM_EN to require a trailing CHK byte,
// CHK = (LEN + sum of payload) mod 256. Without it a frame commits on its
// last payload byte.
//
// Output handshake: a byte transfers on every clk edge where out_valid and
// out_ready are both high; out_valid never drops and out_data/out_last never
// change while out_valid is high and out_ready is low.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter logic [7:0]  SYNC    = SYNC_BYTE,
   parameter int          MAX_LEN = MAX_LEN_DEF,
   parameter int          DEPTH   = DEPTH_DEF,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic         rx_done,
   input  logic [7:0]   rx_data,
   output logic         out_valid,
   output logic [7:0]   out_data,
   output logic         out_last,
   input  logic         out_ready,
   output logic         frame_ok,
   output logic         frame_err,
   output logic [1:0]   err_code,
   output frame_state_t state_dbg
);
   localparam int FW = $clog2(DEPTH) + 1;
   localparam int CW = (FW > 9) ? FW : 9;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   frame_state_t  state_q, state_d;
   logic          rx_done_q;
   logic          byte_evt;
   logic [7:0]    remaining_q;
   logic [15:0]   tmo_q, tmo_d;
   logic          tmo_hit;
   logic          frame_ok_q, frame_err_q;
   logic [1:0]    err_code_q;
   logic [FW-1:0] free;
   logic          len_bad, no_room;
   logic          wr_en, commit, drop, load_len;
   logic [1:0]    drop_code;
`ifdef FRAME_CHECKSUM_EN
   logic [7:0]    sum_q;
`endif

   // A byte arrives on the rising edge of the receiver's done level.
   assign byte_evt = rx_done & ~rx_done_q;
   assign len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
   assign no_room  = CW'(free) < CW'(rx_data);
   // A byte in the same cycle always wins over the timeout.
   assign tmo_hit  = (state_q != ST_HUNT) && !byte_evt && (tmo_q >= TIMEOUT);
   assign tmo_d    = (state_q == ST_HUNT || byte_evt) ? 16'd0 : tmo_q + 16'd1;

   // State register.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; any drop returns to HUNT without re-examining the byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HUNT: begin
            if (byte_evt && rx_data == SYNC) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (byte_evt) state_d = (len_bad || no_room) ? ST_HUNT : ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
`ifdef FRAME_CHECKSUM_EN
            if (byte_evt && remaining_q == 8'd1) state_d = ST_CHECK;
`else
            if (byte_evt && remaining_q == 8'd1) state_d = ST_HUNT;
`endif
         end
         ST_CHECK: begin
            if (byte_evt) state_d = ST_HUNT;
         end
         default: state_d = ST_HUNT;
      endcase
      if (tmo_hit) state_d = ST_HUNT;
   end

   // Per-state actions: FIFO write, commit, drop with reason, length load.
   always_comb begin
      wr_en     = 1'b0;
      commit    = 1'b0;
      drop      = 1'b0;
      drop_code = ERR_LEN;
      load_len  = 1'b0;
      case (state_q)
         ST_LEN: begin
            if (byte_evt) begin
               if (len_bad) begin
                  drop      = 1'b1;
                  drop_code = ERR_LEN;
               end else if (no_room) begin
                  drop      = 1'b1;
                  drop_code = ERR_OVERFLOW;
               end else begin
                  load_len  = 1'b1;
               end
            end
         end
         ST_PAYLOAD: begin
            if (byte_evt) begin
               wr_en = 1'b1;
`ifndef FRAME_CHECKSUM_EN
               if (remaining_q == 8'd1) commit = 1'b1;
`endif
            end
         end
`ifdef FRAME_CHECKSUM_EN
         ST_CHECK: begin
            if (byte_evt) begin
               if (rx_data == sum_q) begin
                  commit    = 1'b1;
               end else begin
                  drop      = 1'b1;
                  drop_code = ERR_CHECKSUM;
               end
            end
         end
`endif
         default: ;
      endcase
      if (tmo_hit) begin
         drop      = 1'b1;
         drop_code = ERR_TIMEOUT;
      end
   end

   // Frame datapath: edge detect, byte countdown, timeout and status pulses.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         rx_done_q   <= 1'b0;
         remaining_q <= 8'd0;
         tmo_q       <= 16'd0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_LEN;
      end else begin
         rx_done_q   <= rx_done;
         tmo_q       <= tmo_d;
         frame_ok_q  <= commit;
         frame_err_q <= drop;
         if (load_len) begin
            remaining_q <= rx_data;
         end else if (wr_en) begin
            remaining_q <= remaining_q - 8'd1;
         end
         if (drop) begin
            err_code_q <= drop_code;
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   // Running checksum seeded with LEN, accumulated over the payload.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         sum_q <= 8'd0;
      end else if (load_len) begin
         sum_q <= rx_data;
      end else if (wr_en) begin
         sum_q <= sum_q + rx_data;
      end
   end
`endif

   frame_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .nRst       (nRst),
      .wr_en_i    (wr_en),
      .wr_data_i  (rx_data),
      .wr_last_i  (remaining_q == 8'd1),
      .commit_i   (commit),
      .rollback_i (drop),
      .rd_en_i    (out_ready),
      .rd_valid_o (out_valid),
      .rd_data_o  (out_data),
      .rd_last_o  (out_last),
      .free_o     (free)
   );

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed and randomized frames; a frame-level model
// predicts delivered bytes and ok/err events, a monitor checks them.
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int          MAX_LEN = 16;
  localparam int          DEPTH   = 32;
  localparam logic [15:0] TIMEOUT = 16'd2000;
  localparam logic [7:0]  SYNC_B  = 8'hA5;

  logic         clk = 1'b0;
  logic         nRst;
  logic         rx_done;
  logic [7:0]   rx_data;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic         frame_ok;
  logic         frame_err;
  logic [1:0]   err_code;
  frame_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;          // 0: never ready, 1: always, 2: random
  logic [8:0] exp_q[$];        // {last, data} of committed bytes
  logic [2:0] evt_q[$];        // 3'b000 = frame_ok, {1, code} = frame_err
  logic [7:0] pl_q[$];         // payload of the frame to send

  uart_frame_rx #(
    .SYNC(SYNC_B), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nRst(nRst), .rx_done(rx_done), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .state_dbg(state_dbg)
  );

  // clock / ready driver
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int hold, input bit lat);
    rx_data = b;
    rx_done = 1'b1;
    step();
    if (lat) begin
      chk("commit_latency_frame_ok", 32'(frame_ok), 32'd1);
      chk("commit_latency_out_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 1; i < hold; i++) step();
    rx_done = 1'b0;
    repeat ($urandom_range(1, 2)) step();
  endtask

  task automatic push_payload(input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({1'(i == len - 1), pl_q[i]});
    evt_q.push_back(3'b000);
  endtask

  // Frame-level reference: outcome decided from LEN, free space and checksum.
  task automatic send_frame(input int len, input bit bad_chk, input bit lat, input int sync_hold);
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] chk_b;
`endif
    send_byte(SYNC_B, sync_hold, 1'b0);
    if (len == 0 || len > MAX_LEN) begin
      evt_q.push_back({1'b1, ERR_LEN});
      send_byte(8'(len), 1, 1'b0);
      return;
    end
    if (DEPTH - exp_q.size() < len) begin
      evt_q.push_back({1'b1, ERR_OVERFLOW});
      send_byte(8'(len), 1, 1'b0);
      return;
    end
    send_byte(8'(len), 1, 1'b0);
`ifdef FRAME_CHECKSUM_EN
    sum = 8'(len);
    for (int i = 0; i < len; i++) sum = sum + pl_q[i];
    for (int i = 0; i < len; i++) send_byte(pl_q[i], $urandom_range(1, 2), 1'b0);
    chk_b = bad_chk ? sum + 8'($urandom_range(1, 255)) : sum;
    if (chk_b == sum) push_payload(len);
    else evt_q.push_back({1'b1, ERR_CHECKSUM});
    send_byte(chk_b, 1, lat);
`else
    for (int i = 0; i < len - 1; i++) send_byte(pl_q[i], $urandom_range(1, 2), 1'b0);
    push_payload(len);
    send_byte(pl_q[len - 1], 1, lat);
`endif
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || evt_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d/%0d pending want=0/0", exp_q.size(), evt_q.size());
      exp_q.delete();
      evt_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_frame_ok"},  32'(frame_ok),  32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_err_code"},  32'(err_code),  32'd0);
    chk({tag, "_state"},     32'(state_dbg), 32'(ST_HUNT));
  endtask

  // scoreboard monitor
  initial begin
    logic [8:0] e;
    logic [2:0] got;
    forever begin
      @(negedge clk);
      if (nRst) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected got=%0h want=none", {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", 32'({out_last, out_data}), 32'(e));
          end
        end
        if (frame_ok || frame_err) begin
          got = frame_err ? {1'b1, err_code} : 3'b000;
          if (frame_ok && frame_err) got = 3'b011;
          if (evt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL evt_unexpected got=%0h want=none", got);
          end else begin
            chk("frame_event", 32'(got), 32'(evt_q.pop_front()));
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int len;
    int kind;
    int n;
    logic [7:0] g;
    nRst = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) step();
    check_reset_outputs("reset");
    nRst = 1'b1;
    step();

    // leading junk ignored, 3-byte frame, commit latency
    ready_mode = 1;
    step();
    send_byte(8'h00, 1, 1'b0);
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame(3, 1'b0, 1'b1, 1);
    wait_idle(200);

    // corrupted checksum
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame(3, 1'b1, 1'b0, 1);
    wait_idle(200);

    // zero length, then single-byte frame
    send_frame(0, 1'b0, 1'b0, 1);
    pl_q = '{8'h7E};
    send_frame(1, 1'b0, 1'b0, 1);
    wait_idle(200);

    // overflow with stalled consumer, then accept after partial drain
    ready_mode = 0;
    repeat (2) step();
    for (int f = 0; f < 3; f++) begin
      pl_q.delete();
      for (int i = 0; i < 16; i++) pl_q.push_back(8'($urandom_range(0, 255)));
      send_frame(16, 1'b0, 1'b0, 1);
    end
    n = 0;
    while (evt_q.size() != 0 && n < 100) begin step(); n++; end
    chk("overflow_events_seen", 32'(evt_q.size()), 32'd0);
    ready_mode = 1;
    n = 0;
    while (exp_q.size() > 16 && n < 200) begin step(); n++; end
    ready_mode = 0;
    repeat (3) step();
    chk("partial_drain_left", 32'(exp_q.size()), 32'd16);
    send_frame(16, 1'b0, 1'b0, 1);
    ready_mode = 1;
    wait_idle(300);

    // inter-byte timeout, then a long rx_done level counts once
    send_byte(SYNC_B, 1, 1'b0);
    send_byte(8'h02, 1, 1'b0);
    send_byte(8'h55, 1, 1'b0);
    evt_q.push_back({1'b1, ERR_TIMEOUT});
    wait_idle(int'(TIMEOUT) + 100);
    pl_q = '{8'h33};
    send_frame(1, 1'b0, 1'b0, 1000);
    wait_idle(200);

    // reset mid-frame discards committed and partial data
    ready_mode = 0;
    step();
    pl_q = '{8'h44, 8'h45};
    send_frame(2, 1'b0, 1'b0, 1);
    n = 0;
    while (evt_q.size() != 0 && n < 50) begin step(); n++; end
    send_byte(SYNC_B, 1, 1'b0);
    send_byte(8'h02, 1, 1'b0);
    send_byte(8'h55, 1, 1'b0);
    nRst = 1'b0;
    repeat (2) step();
    check_reset_outputs("midreset");
    exp_q.delete();
    evt_q.delete();
    nRst = 1'b1;
    step();
    ready_mode = 1;
    pl_q = '{8'h01, 8'hA5, 8'hFF, 8'h80};
    send_frame(4, 1'b0, 1'b0, 1);
    wait_idle(200);

    // randomized frames with a randomly stalling consumer
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      n = 0;
      while (exp_q.size() > DEPTH - MAX_LEN && n < 500) begin step(); n++; end
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC_B) g = 8'h00;
        send_byte(g, $urandom_range(1, 3), 1'b0);
      end
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, MAX_LEN);
      if (kind == 0) len = 0;
      if (kind == 1) len = $urandom_range(MAX_LEN + 1, 255);
      pl_q.delete();
      for (int i = 0; i < len && i < MAX_LEN; i++) pl_q.push_back(8'($urandom_range(0, 255)));
      send_frame(len, (kind == 2), 1'b0, $urandom_range(1, 3));
    end
    ready_mode = 1;
    wait_idle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Byte-stream deframer sitting directly downstream of the UART receiver. Consumes each received byte, hunts for a sync byte, parses a length-prefixed frame with checksum, and buffers the payload in a commit/rollback FIFO. Only complete, verified frames become visible on a valid/ready byte stream, with the last byte of each frame flagged. Corrupt, oversized or stalled frames are dropped and reported.

## Interface
- SYNC, 8'hA5, frame start byte
- MAX_LEN, 16, largest legal payload length (1..255)
- DEPTH, 32, payload FIFO entries (power of 2, ≥ MAX_LEN)
- TIMEOUT, 16'd50000, inter-byte timeout in clk cycles
- clk  in  1  system clock
- nRst  in  1  reset; synchronous, active-low
- rx_done  in  1  byte-received level from UART receiver; a new byte is signalled by its rising edge
- rx_data  in  8  received byte; stable while rx_done high
- out_valid  out  1  committed payload byte available
- out_data  out  8  payload byte
- out_last  out  1  out_data is final byte of its frame
- out_ready  in  1  consumer accepts byte when out_valid & out_ready
- frame_ok  out  1  one-cycle pulse, frame committed
- frame_err  out  1  one-cycle pulse, frame dropped
- err_code  out  2  reason of last drop: 0 LEN, 1 OVERFLOW, 2 CHECKSUM, 3 TIMEOUT; holds until next drop

## Operation
- Byte event: rx_done registered into rx_done_q; event = rx_done & ~rx_done_q. Byte taken from rx_data on that edge. rx_done held high for many cycles yields exactly one event.
- Frame: SYNC, LEN, LEN payload bytes, CHK. CHK = (LEN + Σpayload) mod 256, 8-bit wrap.
- States: HUNT, LEN, PAYLOAD, CHECK.
- HUNT: non-SYNC bytes ignored; SYNC → LEN.
- LEN: LEN==0 or > MAX_LEN → drop code 0, HUNT. Free entries (DEPTH − (wr_ptr − rd_ptr)) < LEN → drop code 1, HUNT. Else load remaining=LEN, sum=LEN → PAYLOAD.
- PAYLOAD: byte written at wr_ptr with last=(remaining==1); sum+=byte; remaining−=1; at remaining 1 → CHECK.
- CHECK: CHK==sum → commit_ptr<=wr_ptr, frame_ok, HUNT. Else drop code 2.
- Drop: wr_ptr<=commit_ptr (rollback), frame_err pulse, err_code updated, HUNT. A byte causing a drop is not re-examined as SYNC.
- Timeout: counter cleared on every byte event and in HUNT; in any other state reaching TIMEOUT → drop code 3.
- Read side: out_valid = (rd_ptr != commit_ptr); uncommitted bytes never visible. Pop on out_valid & out_ready.
- Pointers log2(DEPTH)+1 bits, natural wrap; full/empty by MSB compare.

## Timing
- Reset: out_valid 0, out_data 0, out_last 0, frame_ok 0, frame_err 0, err_code 0, FIFO empty, state HUNT, timeout 0, rx_done_q 0.
- Byte event processed on first clk edge where rx_done sampled high with rx_done_q 0.
- CHK event edge → frame_ok high and out_valid high the following cycle (first payload byte latency 1 cycle from commit edge).
- out_data/out_last are registered FIFO read data, valid whenever out_valid; sustains one byte per cycle.
- Byte event and timeout same cycle: byte wins, counter cleared.
- Commit and pop same cycle: both take effect.
- Overflow check uses occupancy at LEN edge, so concurrent pops can only increase space; no overflow during PAYLOAD possible.
- nRst low mid-frame: partial frame discarded, committed data discarded, no frame_err.

## Configuration
- FRAME_CHECKSUM_EN defined: CHECK state and CHK byte as above; code 2 reachable.
- Undefined: no CHK byte; frame commits on the edge of the last payload byte (frame_ok then); sum logic absent; code 2 never produced.

## Structure
- Package uart_frame_pkg: state enum, err_code localparams (ERR_LEN, ERR_OVERFLOW, ERR_CHECKSUM, ERR_TIMEOUT), default SYNC.
- Sub-module frame_fifo: 9-bit-wide (data+last) DEPTH-entry FIFO with wr_ptr, commit_ptr, rd_ptr, commit and rollback inputs, free-count output.

## Test plan
- Bytes 00 A5 03 11 22 33 69, out_ready 1 → out 11,22,33, out_last only on 33, one frame_ok, leading 00 ignored.
- A5 03 11 22 33 00 → frame_err, err_code 2, out_valid never high.
- A5 00 then A5 01 7E 7F → drop code 0, then out 7E with out_last, frame_ok.
- out_ready 0, DEPTH 32: two 16-byte frames commit, third A5 10 → drop code 1; after draining 16, same frame accepted.
- A5 02 55, idle TIMEOUT cycles → drop code 3; rx_done held high 1000 cycles counts as one byte.
- nRst low after A5 02 55 → all outputs 0; next good frame delivered intact.
